// File: rtl/dram_wr_router_if.sv
// Bundled client and RAM-side signals of the DRAM write router.
// slave: router side. master: the environment driving both clients and watching the RAM port.
interface dram_wr_router_if #(
  parameter int D_LEN      = 16,
  parameter int DA_AWIDTH  = 8,
  parameter int OFS_WIDTH  = 4,
  parameter int RAM_AWIDTH = 12
);
  // input-module client
  logic                  ipm_request;
  logic                  ipm_finish;
  logic                  ipm_wen;
  logic [DA_AWIDTH-1:0]  ipm_base;
  logic [OFS_WIDTH-1:0]  ipm_offset;
  logic [D_LEN-1:0]      ipm_din;
  logic                  ipm_enable;
  // layer-compute-module client
  logic                  lcm_request;
  logic                  lcm_finish;
  logic                  lcm_wen;
  logic [DA_AWIDTH-1:0]  lcm_base;
  logic [OFS_WIDTH-1:0]  lcm_offset;
  logic [D_LEN-1:0]      lcm_din;
  logic                  lcm_enable;
  // data RAM write port and status
  logic                  ram_wen;
  logic [RAM_AWIDTH-1:0] ram_waddr;
  logic [D_LEN-1:0]      ram_din;
  logic                  busy;
  logic                  timeout_err;

  modport slave (
    input  ipm_request, ipm_finish, ipm_wen, ipm_base, ipm_offset, ipm_din,
    input  lcm_request, lcm_finish, lcm_wen, lcm_base, lcm_offset, lcm_din,
    output ipm_enable, lcm_enable,
    output ram_wen, ram_waddr, ram_din, busy, timeout_err
  );

  modport master (
    output ipm_request, ipm_finish, ipm_wen, ipm_base, ipm_offset, ipm_din,
    output lcm_request, lcm_finish, lcm_wen, lcm_base, lcm_offset, lcm_din,
    input  ipm_enable, lcm_enable,
    input  ram_wen, ram_waddr, ram_din, busy, timeout_err
  );
endinterface

// File: rtl/dram_wr_router.sv
// Arbitrates the data-RAM write port between the input module (ipm, higher
// priority) and the layer compute module (lcm). A granted client writes at
// base*CELL_N + offset; a watchdog revokes a grant that stays silent too long.
module dram_wr_router #(
  parameter int D_LEN      = 16,
  parameter int DA_AWIDTH  = 8,
  parameter int OFS_WIDTH  = 4,
  parameter int CELL_N     = 16,
  parameter int RAM_AWIDTH = 12,
  parameter int TIMEOUT    = 2_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  dram_wr_router_if.slave  bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_IPM,
    GRANT_LCM,
    RELEASE
  } state_t;

  state_t               state;
  logic [WD_W-1:0]      wd_cnt;

  logic                 g_wen;
  logic                 g_finish;
  logic [DA_AWIDTH-1:0] g_base;
  logic [OFS_WIDTH-1:0] g_offset;
  logic [D_LEN-1:0]     g_din;
  logic [31:0]          addr_full;
  logic                 wd_expire;

  // Select the granted client's strobe, finish and write data; a non-granted client is invisible.
  always_comb begin
    g_wen    = 1'b0;
    g_finish = 1'b0;
    g_base   = '0;
    g_offset = '0;
    g_din    = '0;
    case (state)
      GRANT_IPM: begin
        g_wen    = bus.ipm_wen;
        g_finish = bus.ipm_finish;
        g_base   = bus.ipm_base;
        g_offset = bus.ipm_offset;
        g_din    = bus.ipm_din;
      end
      GRANT_LCM: begin
        g_wen    = bus.lcm_wen;
        g_finish = bus.lcm_finish;
        g_base   = bus.lcm_base;
        g_offset = bus.lcm_offset;
        g_din    = bus.lcm_din;
      end
      default: ;
    endcase
    // Wide intermediate; truncation to RAM_AWIDTH gives the intended wrap.
    addr_full = 32'(g_base) * 32'(CELL_N) + 32'(g_offset);
    wd_expire = !g_wen && (wd_cnt == WD_MAX);
  end

  // Arbitration FSM with registered grants, RAM write port and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wd_cnt          <= '0;
      bus.ipm_enable  <= 1'b0;
      bus.lcm_enable  <= 1'b0;
      bus.ram_wen     <= 1'b0;
      bus.ram_waddr   <= '0;
      bus.ram_din     <= '0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.ram_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ipm_request) begin
            state           <= GRANT_IPM;
            bus.ipm_enable  <= 1'b1;
            bus.busy        <= 1'b1;
            bus.timeout_err <= 1'b0;
            wd_cnt          <= '0;
          end else if (bus.lcm_request) begin
            state           <= GRANT_LCM;
            bus.lcm_enable  <= 1'b1;
            bus.busy        <= 1'b1;
            bus.timeout_err <= 1'b0;
            wd_cnt          <= '0;
          end
        end
        GRANT_IPM, GRANT_LCM: begin
          if (g_wen) begin
            bus.ram_wen   <= 1'b1;
            bus.ram_waddr <= addr_full[RAM_AWIDTH-1:0];
            bus.ram_din   <= g_din;
            wd_cnt        <= '0;
          end else if (!wd_expire) begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
          // A strobe coinciding with finish has already been captured above.
          if (g_finish || wd_expire) begin
            state          <= RELEASE;
            bus.ipm_enable <= 1'b0;
            bus.lcm_enable <= 1'b0;
            bus.busy       <= 1'b0;
            if (wd_expire) bus.timeout_err <= 1'b1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_wr_router.sv
// Directed bench for dram_wr_router: expected RAM writes are queued when a
// strobe is driven and popped by a monitor when ram_wen appears.
module tb_dram_wr_router;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_pass;
  int   n_total;

  typedef struct {
    int          due;
    logic [7:0]  addr;
    logic [15:0] din;
  } exp_t;

  exp_t sb[$];

  dram_wr_router_if #(.D_LEN(16), .DA_AWIDTH(8), .OFS_WIDTH(4), .RAM_AWIDTH(8)) bus ();

  dram_wr_router #(
    .D_LEN(16), .DA_AWIDTH(8), .OFS_WIDTH(4), .CELL_N(16), .RAM_AWIDTH(8), .TIMEOUT(10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Drive a write strobe on one client; queue the expected RAM write when it should land.
  task automatic strobe(input bit lcm, input logic [7:0] b, input logic [3:0] o,
                        input logic [15:0] d, input bit exp_wr);
    exp_t e;
    int   a;
    if (lcm) begin
      bus.lcm_wen = 1'b1; bus.lcm_base = b; bus.lcm_offset = o; bus.lcm_din = d;
    end else begin
      bus.ipm_wen = 1'b1; bus.ipm_base = b; bus.ipm_offset = o; bus.ipm_din = d;
    end
    if (exp_wr) begin
      a      = int'(b) * 16 + int'(o);
      e.due  = cyc + 1;
      e.addr = 8'(a % 256);
      e.din  = d;
      sb.push_back(e);
    end
  endtask

  task automatic clr_wen();
    bus.ipm_wen = 1'b0;
    bus.lcm_wen = 1'b0;
  endtask

  // RAM write monitor: every ram_wen pulse must match the oldest queued write, on time.
  always @(negedge clk) begin
    exp_t e;
    if (bus.ram_wen === 1'b1) begin
      if (sb.size() == 0) begin
        check("ram_wen_spurious", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("wr_cycle", 64'(cyc), 64'(e.due));
        check("wr_addr", 64'(bus.ram_waddr), 64'(e.addr));
        check("wr_din", 64'(bus.ram_din), 64'(e.din));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: observed timeout expected finish");
    $fatal(1, "time limit");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ipm_en"}, 64'(bus.ipm_enable), 64'd0);
    check({tag, "_lcm_en"}, 64'(bus.lcm_enable), 64'd0);
    check({tag, "_ram_wen"}, 64'(bus.ram_wen), 64'd0);
    check({tag, "_waddr"}, 64'(bus.ram_waddr), 64'd0);
    check({tag, "_din"}, 64'(bus.ram_din), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_tout"}, 64'(bus.timeout_err), 64'd0);
  endtask

  initial begin
    cyc = 0; n_pass = 0; n_total = 0;
    rst_n = 1'b0;
    bus.ipm_request = 1'b0; bus.ipm_finish = 1'b0; bus.ipm_wen = 1'b0;
    bus.ipm_base = '0; bus.ipm_offset = '0; bus.ipm_din = '0;
    bus.lcm_request = 1'b0; bus.lcm_finish = 1'b0; bus.lcm_wen = 1'b0;
    bus.lcm_base = '0; bus.lcm_offset = '0; bus.lcm_din = '0;
    repeat (2) step();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Sequential block writes from ipm: base 0 offsets 0..15, then base 1 offset 0.
    bus.ipm_request = 1'b1;
    step();
    check("t1_ipm_en", 64'(bus.ipm_enable), 64'd1);
    check("t1_lcm_en", 64'(bus.lcm_enable), 64'd0);
    check("t1_busy", 64'(bus.busy), 64'd1);
    bus.ipm_request = 1'b0;
    for (int unsigned k = 0; k < 17; k++) begin
      strobe(1'b0, (k < 16) ? 8'd0 : 8'd1, (k < 16) ? 4'(k) : 4'd0, 16'($urandom), 1'b1);
      step();
    end
    clr_wen();
    step();
    check("t1_wen_low", 64'(bus.ram_wen), 64'd0);
    check("t1_addr_hold", 64'(bus.ram_waddr), 64'd16);
    bus.ipm_finish = 1'b1;
    step();
    check("t1_rel_ipm_en", 64'(bus.ipm_enable), 64'd0);
    check("t1_rel_busy", 64'(bus.busy), 64'd0);
    bus.ipm_finish = 1'b0;
    step();
    check("t1_idle_busy", 64'(bus.busy), 64'd0);

    // Simultaneous requests: ipm first, lcm only after RELEASE and IDLE.
    bus.ipm_request = 1'b1; bus.lcm_request = 1'b1;
    step();
    check("t2_ipm_en", 64'(bus.ipm_enable), 64'd1);
    check("t2_lcm_en", 64'(bus.lcm_enable), 64'd0);
    bus.ipm_request = 1'b0;
    bus.ipm_finish = 1'b1;
    step();
    check("t2_rel_ipm", 64'(bus.ipm_enable), 64'd0);
    check("t2_rel_lcm", 64'(bus.lcm_enable), 64'd0);
    bus.ipm_finish = 1'b0;
    step();
    check("t2_idle_lcm", 64'(bus.lcm_enable), 64'd0);
    step();
    check("t2_lcm_en", 64'(bus.lcm_enable), 64'd1);
    check("t2_ipm_off", 64'(bus.ipm_enable), 64'd0);
    bus.lcm_request = 1'b0;
    strobe(1'b1, 8'd20, 4'd5, 16'hA55A, 1'b1);   // 325 mod 256 = 69
    step();
    clr_wen();
    strobe(1'b0, 8'd1, 4'd1, 16'h1111, 1'b0);    // non-granted client, ignored
    bus.ipm_finish = 1'b1;
    step();
    check("t2_ign_fin", 64'(bus.lcm_enable), 64'd1);
    clr_wen();
    bus.ipm_finish = 1'b0;
    strobe(1'b1, 8'd255, 4'd15, 16'hBEEF, 1'b1); // 4095 wraps to 255
    step();
    clr_wen();
    bus.lcm_finish = 1'b1;
    step();
    check("t2_lcm_rel", 64'(bus.lcm_enable), 64'd0);
    bus.lcm_finish = 1'b0;
    step();

    // lcm activity ignored during ipm grant; strobe together with finish still lands.
    bus.ipm_request = 1'b1;
    step();
    check("t3_ipm_en", 64'(bus.ipm_enable), 64'd1);
    bus.ipm_request = 1'b0;
    bus.lcm_finish = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      strobe(1'b1, 8'(k + 4), 4'(k), 16'(k + 16'h0700), 1'b0);
      step();
    end
    check("t3_no_wen", 64'(bus.ram_wen), 64'd0);
    check("t3_still_ipm", 64'(bus.ipm_enable), 64'd1);
    clr_wen();
    bus.lcm_finish = 1'b0;
    strobe(1'b0, 8'd2, 4'd3, 16'h3C00, 1'b1);    // address 35
    bus.ipm_finish = 1'b1;
    step();
    check("t3_rel_en", 64'(bus.ipm_enable), 64'd0);
    check("t3_rel_busy", 64'(bus.busy), 64'd0);
    clr_wen();
    bus.ipm_finish = 1'b0;
    step();

    // Watchdog: 11 silent grant cycles expire the grant.
    bus.ipm_request = 1'b1;
    step();
    check("t4_ipm_en", 64'(bus.ipm_enable), 64'd1);
    bus.ipm_request = 1'b0;
    repeat (10) step();
    check("t4_before_en", 64'(bus.ipm_enable), 64'd1);
    check("t4_before_to", 64'(bus.timeout_err), 64'd0);
    step();
    check("t4_exp_en", 64'(bus.ipm_enable), 64'd0);
    check("t4_exp_to", 64'(bus.timeout_err), 64'd1);
    check("t4_exp_busy", 64'(bus.busy), 64'd0);
    step();
    check("t4_sticky_to", 64'(bus.timeout_err), 64'd1);
    bus.lcm_request = 1'b1;
    step();
    check("t4_regrant_en", 64'(bus.lcm_enable), 64'd1);
    check("t4_regrant_to", 64'(bus.timeout_err), 64'd0);
    bus.lcm_request = 1'b0;
    repeat (8) step();
    strobe(1'b1, 8'd7, 4'd7, 16'h7777, 1'b1);    // restarts the watchdog
    step();
    clr_wen();
    repeat (10) step();
    check("t4_wdrst_en", 64'(bus.lcm_enable), 64'd1);
    step();
    check("t4_wdrst_exp_en", 64'(bus.lcm_enable), 64'd0);
    check("t4_wdrst_exp_to", 64'(bus.timeout_err), 64'd1);
    step();

    // Reset during an lcm grant with a write just registered: everything clears at once.
    bus.lcm_request = 1'b1;
    step();
    check("t5_lcm_en", 64'(bus.lcm_enable), 64'd1);
    check("t5_to_clr", 64'(bus.timeout_err), 64'd0);
    bus.lcm_request = 1'b0;
    strobe(1'b1, 8'd9, 4'd9, 16'h9999, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_rst");
    step();
    clr_wen();
    step();
    rst_n = 1'b1;
    bus.lcm_request = 1'b1;
    step();
    check("t5_first_grant", 64'(bus.lcm_enable), 64'd1);
    bus.lcm_request = 1'b0;
    strobe(1'b1, 8'd1, 4'd2, 16'h1234, 1'b1);
    step();
    clr_wen();
    bus.lcm_finish = 1'b1;
    step();
    bus.lcm_finish = 1'b0;
    repeat (3) step();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
